// File: rtl/uwire_rx_if.sv
// MICROWIRE receive-monitor bundle: the three serial lines in, received words,
// status and shadow read port out.
interface uwire_rx_if;
    logic        DATAuWire;
    logic        CLKuWire;
    logic        LEuWire;
    logic [31:0] word;
    logic [4:0]  addr;
    logic        word_valid;
    logic        frame_err;
    logic [5:0]  err_bits;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        state_dbg;

    // Handshake: word_valid and frame_err are single-cycle qualifiers with no
    // ready; a consumer samples word/addr or err_bits in the cycle the pulse is
    // high. The two pulses never coincide.
    modport master (
        output DATAuWire, CLKuWire, LEuWire, rd_addr,
        input  word, addr, word_valid, frame_err, err_bits, busy, frame_cnt,
               rd_data, state_dbg
    );

    modport slave (
        input  DATAuWire, CLKuWire, LEuWire, rd_addr,
        output word, addr, word_valid, frame_err, err_bits, busy, frame_cnt,
               rd_data, state_dbg
    );
endinterface

// File: rtl/uwire_rx_monitor.sv
// Receive-side MICROWIRE monitor: synchronises DATA/CLK/LE, shifts MSB-first and
// reports 32-bit frames on LE rise. Macro UWIRE_RX_SHADOW_EN adds a 32x32 shadow file.
module uwire_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 32
) (
    input  logic     clk,
    input  logic     rst,
    uwire_rx_if.slave bus
);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {ST_WARM = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [WARM_W-1:0]       warm_cnt_q, warm_cnt_d;
    logic [SYNC_STAGES-1:0]  data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]  le_sync_q, le_sync_d;
    logic                    clk_prev_q, clk_prev_d;
    logic                    le_prev_q, le_prev_d;
    logic [WORD_BITS-1:0]    shift_q, shift_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]    word_q, word_d;
    logic [4:0]              addr_q, addr_d;
    logic                    word_valid_q, word_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic [5:0]              err_bits_q, err_bits_d;
    logic                    busy_q, busy_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [31:0]             rd_data_q, rd_data_d;

    logic                    clk_line, le_line, data_line;
    logic                    clk_rise, le_rise, do_shift;
    logic [WORD_BITS-1:0]    shift_new;
    logic [5:0]              cnt_new;

    always_comb begin
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.DATAuWire};
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.CLKuWire};
        le_sync_d   = {le_sync_q[SYNC_STAGES-2:0], bus.LEuWire};
        data_line   = data_sync_q[SYNC_STAGES-1];
        clk_line    = clk_sync_q[SYNC_STAGES-1];
        le_line     = le_sync_q[SYNC_STAGES-1];
        clk_prev_d  = clk_line;
        le_prev_d   = le_line;

        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        case (state_q)
            ST_WARM: begin
                if (warm_cnt_q == WARM_W'(SYNC_STAGES)) begin
                    state_d = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Edges are suppressed while warming up so a line high at reset release is silent.
        clk_rise = (state_q == ST_RUN) && clk_line && !clk_prev_q;
        le_rise  = (state_q == ST_RUN) && le_line && !le_prev_q;

        // A CLK rise coinciding with the LE rise still lands before the frame check.
        do_shift  = clk_rise && (!le_line || le_rise);
        shift_new = shift_q;
        cnt_new   = bit_cnt_q;
        if (do_shift) begin
            shift_new = {shift_q[WORD_BITS-2:0], data_line};
            cnt_new   = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
        end

        shift_d      = shift_new;
        bit_cnt_d    = cnt_new;
        word_d       = word_q;
        addr_d       = addr_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_bits_d   = err_bits_q;
        frame_cnt_d  = frame_cnt_q;
        if (le_rise) begin
            bit_cnt_d = 6'd0;
            if (cnt_new == 6'(WORD_BITS)) begin
                word_d       = shift_new;
                addr_d       = shift_new[4:0];
                word_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
                frame_err_d = 1'b1;
                err_bits_d  = cnt_new;
            end
        end
        busy_d = (bit_cnt_d != 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WARM;
            warm_cnt_q   <= '0;
            data_sync_q  <= '0;
            clk_sync_q   <= '0;
            le_sync_q    <= '0;
            clk_prev_q   <= 1'b0;
            le_prev_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_bits_q   <= '0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            data_sync_q  <= data_sync_d;
            clk_sync_q   <= clk_sync_d;
            le_sync_q    <= le_sync_d;
            clk_prev_q   <= clk_prev_d;
            le_prev_q    <= le_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            err_bits_q   <= err_bits_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef UWIRE_RX_SHADOW_EN
    logic [31:0] shadow_q [32];

    always_comb begin
        rd_data_d = shadow_q[bus.rd_addr];
    end

    // Read and write share an edge, so a same-address read returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (word_valid_q) begin
                shadow_q[addr_q] <= word_q;
            end
            rd_data_q <= rd_data_d;
        end
    end
`else
    logic unused_rd_addr;

    always_comb begin
        rd_data_d      = '0;
        unused_rd_addr = ^bus.rd_addr;
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end
`endif

    assign bus.word       = word_q;
    assign bus.addr       = addr_q;
    assign bus.word_valid = word_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_bits   = err_bits_q;
    assign bus.busy       = busy_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_uwire_rx_monitor.sv
// Directed plus randomized frames against a frame-level reference model of uwire_rx_monitor.
module tb_uwire_rx_monitor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uwire_rx_if bus();

    uwire_rx_monitor #(.SYNC_STAGES(2), .WORD_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int both_cnt = 0;

    // Events encoded as {is_err, err_bits[5:0], word[31:0]}.
    logic [38:0] exp_q[$];
    logic [38:0] obs_q[$];

    logic [31:0] mdl_word;
    logic [15:0] mdl_cnt;
    logic [31:0] mdl_shadow [32];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.word_valid && bus.frame_err) both_cnt++;
            if (bus.word_valid) obs_q.push_back({1'b0, 6'd0, bus.word});
            if (bus.frame_err)  obs_q.push_back({1'b1, bus.err_bits, 32'd0});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mdl_word = '0;
        mdl_cnt  = '0;
        for (int i = 0; i < 32; i++) mdl_shadow[i] = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send_bits(input int n, input logic [63:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            bus.DATAuWire = v[i];
            wait_cyc(10);
            bus.CLKuWire = 1'b1;
            wait_cyc(10);
            bus.CLKuWire = 1'b0;
        end
    endtask

    // Raise LE, measure pulse latency, optionally toggle CLK while LE is high.
    task automatic le_high(input int n_clk);
        int lat;
        lat = -1;
        wait_cyc(10);
        bus.LEuWire = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (lat < 0 && (bus.word_valid || bus.frame_err)) lat = k;
            @(posedge clk);
        end
        #1;
        check("latency", 64'(lat), 64'd3);
        for (int i = 0; i < n_clk; i++) begin
            bus.DATAuWire = 1'($urandom_range(0, 1));
            bus.CLKuWire = 1'b1;
            wait_cyc(10);
            bus.CLKuWire = 1'b0;
            wait_cyc(10);
        end
        @(negedge clk);
        check("busy_le_high", 64'(bus.busy), 64'd0);
        wait_cyc(1);
        bus.LEuWire = 1'b0;
        wait_cyc(10);
    endtask

    task automatic expect_frame(input int n, input logic [63:0] v);
        if (n == 32) begin
            exp_q.push_back({1'b0, 6'd0, v[31:0]});
            mdl_word = v[31:0];
            mdl_cnt  = mdl_cnt + 16'd1;
            mdl_shadow[v[4:0]] = v[31:0];
        end else begin
            exp_q.push_back({1'b1, (n > 63) ? 6'd63 : 6'(n), 32'd0});
        end
    endtask

    task automatic compare_events(input string tag);
        @(negedge clk);
        check({tag, "_evcount"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_event"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_word"}, 64'(bus.word), 64'(mdl_word));
        check({tag, "_addr"}, 64'(bus.addr), 64'(mdl_word[4:0]));
        check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(mdl_cnt));
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        wait_cyc(1);
    endtask

    task automatic do_frame(input string tag, input int n, input logic [63:0] v, input int n_clk);
        send_bits(n, v);
        expect_frame(n, v);
        le_high(n_clk);
        compare_events(tag);
    endtask

    initial begin
        logic [63:0] rv;
        int n;
        rst = 1'b1;
        bus.DATAuWire = 1'b0;
        bus.CLKuWire  = 1'b0;
        bus.LEuWire   = 1'b0;
        bus.rd_addr   = '0;
        model_reset();
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        check("rst_word", 64'(bus.word), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_err_bits", 64'(bus.err_bits), 64'd0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_pulses", 64'({bus.word_valid, bus.frame_err, bus.busy}), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        wait_cyc(1);

        do_frame("f80012345", 32, 64'h8001_2345, 0);

        rv = 64'($urandom);
        send_bits(31, rv);
        wait_cyc(5);
        @(negedge clk);
        check("busy_mid_frame", 64'(bus.busy), 64'd1);
        wait_cyc(1);
        expect_frame(31, rv);
        le_high(0);
        compare_events("short31");

        do_frame("f0000001f", 32, 64'h0000_001F, 0);
        do_frame("long40_le_held", 40, {$urandom, $urandom}, 5);

        rst = 1'b1;
        bus.CLKuWire = 1'b1;
        bus.LEuWire  = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        model_reset();
        wait_cyc(12);
        @(negedge clk);
        check("hi_lines_events", 64'(obs_q.size()), 64'd0);
        check("hi_lines_busy", 64'(bus.busy), 64'd0);
        check("hi_lines_state", 64'(bus.state_dbg), 64'd1);
        wait_cyc(1);
        bus.CLKuWire = 1'b0;
        bus.LEuWire  = 1'b0;
        wait_cyc(10);
        compare_events("hi_lines_release");

        send_bits(16, 64'($urandom));
        rst = 1'b1;
        bus.DATAuWire = 1'b0;
        wait_cyc(3);
        rst = 1'b0;
        model_reset();
        wait_cyc(6);
        do_frame("fdeadbee0", 32, 64'hDEAD_BEE0, 0);

        for (int i = 0; i < 8; i++) begin
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : 32;
            rv = {$urandom, $urandom};
            do_frame("random", n, rv, int'($urandom_range(0, 2)));
        end

`ifdef UWIRE_RX_SHADOW_EN
        do_frame("sh_11111103", 32, 64'h1111_1103, 0);
        do_frame("sh_22222203", 32, 64'h2222_2203, 0);
        bus.rd_addr = 5'd3;
        wait_cyc(1);
        @(negedge clk);
        check("shadow_rd3", 64'(bus.rd_data), 64'h2222_2203);
        wait_cyc(1);
        bus.rd_addr = 5'd4;
        wait_cyc(1);
        @(negedge clk);
        check("shadow_rd4", 64'(bus.rd_data), 64'(mdl_shadow[4]));
        for (int a = 0; a < 32; a += 7) begin
            wait_cyc(1);
            bus.rd_addr = 5'(a);
            wait_cyc(1);
            @(negedge clk);
            check("shadow_sweep", 64'(bus.rd_data), 64'(mdl_shadow[a]));
        end
`else
        for (int a = 0; a < 32; a += 9) begin
            bus.rd_addr = 5'(a);
            wait_cyc(2);
            @(negedge clk);
            check("rd_data_tied", 64'(bus.rd_data), 64'd0);
        end
`endif

        check("no_dual_pulse", 64'(both_cnt), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uwire_rx_monitor.md
Name: uwire_rx_monitor

Overview:
- Receive-side counterpart of the LMK04816 MICROWIRE transmitter.
- Samples the DATAuWire/CLKuWire/LEuWire lines in the local clk domain, shifts data in MSB-first on CLK rising edges, and presents the 32-bit word on each LE rising edge.
- Used in loopback test benches and on-board bus snooping to verify clock-chip programming; flags malformed frames.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input line (minimum 2).
- WORD_BITS, 32, expected bits per frame; fixed at 32 for LMK04816 (addr = word[4:0]).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- DATAuWire  in  1  serial data, asynchronous to clk
- CLKuWire  in  1  serial clock, asynchronous to clk
- LEuWire  in  1  latch enable, asynchronous to clk
- word  out  32  last valid received word
- addr  out  5  word[4:0] of last valid word
- word_valid  out  1  one-cycle pulse when word/addr update
- frame_err  out  1  one-cycle pulse on LE rise with bad bit count
- err_bits  out  6  bit count captured at last frame_err
- busy  out  1  high while bit count is non-zero
- frame_cnt  out  16  count of valid frames, wraps 0xFFFF->0
- rd_addr  in  5  shadow register read address (optional feature)
- rd_data  out  32  shadow register read data (optional feature)

Behaviour:
- Reset: word=0, addr=0, word_valid=0, frame_err=0, err_bits=0, busy=0, frame_cnt=0, rd_data=0. Synchroniser flops, edge-detect registers and shift register are all cleared.
- Input stage: each line passes through SYNC_STAGES flops. An edge-detect register holds the previous synchronised value.
  - rise = sync & ~prev.
- Post-reset warm-up: for SYNC_STAGES+1 cycles after rst deasserts, prev tracks sync and all edges are ignored. A line already high at reset release therefore produces no false edge.
- CLK rise with LE low:
  - shift = {shift[30:0], data_sync};
  - bit_cnt += 1, saturating at 63.
- CLK rise with LE high: ignored (no shift, no count).
- LE rise:
  - bit_cnt == 32: word <= shift, addr <= shift[4:0], word_valid pulses, frame_cnt += 1.
  - Otherwise: word/addr unchanged, frame_err pulses, err_bits <= bit_cnt.
  - In both cases bit_cnt <= 0 on the following cycle.
- Simultaneous CLK rise and LE rise in the same cycle: the CLK shift and count are applied first, and the LE decision uses the updated count. The word is formed combinationally from the new shift value.
- Latency: if the first synchroniser flop captures LE=1 at edge t, word_valid/frame_err are high during the cycle after edge t+SYNC_STAGES.
- Input timing: every CLK/LE high or low phase must last at least SYNC_STAGES+1 clk cycles. Shorter pulses may be missed; this is not detected.
- word_valid and frame_err are never high together, and each is high for exactly one cycle.
- busy = (bit_cnt != 0), registered.
- Reset mid-frame: the partial frame is discarded, and warm-up rule applies again.
- LE held high across multiple frames: only one LE rise is processed; CLK edges are ignored until LE falls.

Optional Feature:
- Macro: UWIRE_RX_SHADOW_EN.
- Defined:
  - 32-entry x 32-bit shadow register file, reset to 0.
  - On word_valid, entry[addr] <= word.
  - rd_data <= entry[rd_addr], registered, one-cycle read latency.
  - A same-cycle write and read to the same address returns the old value; the new value appears one cycle later.
- Not defined: no storage; rd_data tied to 0; rd_addr unused.

Test Plan:
- Send 32-bit frame 0x8001_2345 (CLK half-period 10 clk, LE high 10 clk) -> one word_valid pulse; word=0x80012345, addr=0x05, frame_cnt=1, no frame_err.
- Send 31-bit frame then LE -> frame_err pulse, err_bits=31, word unchanged, frame_cnt unchanged; next proper 32-bit frame 0x0000_001F -> word_valid, addr=0x1F.
- Send 40 bits then LE -> frame_err, err_bits=40; send CLK pulses while LE high -> no shift, busy stays 0.
- Hold CLKuWire=1 and LEuWire=1 through reset release -> no word_valid, no frame_err, bit_cnt stays 0 after warm-up.
- Assert rst after 16 bits of a frame, then send full frame 0xDEAD_BEE0 -> only that frame reported; word=0xDEADBEE0, addr=0x00.
- With UWIRE_RX_SHADOW_EN: write frames 0x1111_1103 and 0x2222_2203 (both addr 3), then rd_addr=3 -> rd_data=0x22222203 one cycle later; rd_addr=4 -> 0.
